// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial shift-and-add / shift-and-subtract arithmetic units.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StZero,
      StDone
   } arith_state_e;

   // Bits needed to hold values 0..n-1; called as clog2(W+1) to size a 0..W counter.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r_bits;
      int unsigned r_span;
      r_bits = 0;
      r_span = 1;
      while (r_span < n) begin
         r_span = r_span << 1;
         r_bits = r_bits + 1;
      end
      return r_bits;
   endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring shift-and-subtract step: shift the next dividend bit into R and
// subtract the divisor when it fits.
module restoring_div_step
   import serial_arith_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W:0]   i_rem,
   input  logic [W-1:0] i_quo,
   input  logic [W-1:0] i_divisor,
   output logic [W:0]   o_rem,
   output logic [W-1:0] o_quo
);

   logic [W:0] w_shift;
   logic       w_ge;
   logic       w_unused_rem_msb;

   // R is always below the divisor between steps, so its top bit is never set.
   assign w_unused_rem_msb = i_rem[W];

   assign w_shift = {i_rem[W-1:0], i_quo[W-1]};
   assign w_ge    = (w_shift >= {1'b0, i_divisor});
   assign o_rem   = w_ge ? (w_shift - {1'b0, i_divisor}) : w_shift;
   assign o_quo   = {i_quo[W-2:0], w_ge};

endmodule

// File: rtl/serial_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Define SERIAL_DIV_SIGNED_EN for two's-complement operands (sign fix-up on entry to done).
module serial_divider
   import serial_arith_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_start,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_quotient,
   output logic [W-1:0] o_remainder,
   output logic         o_div_by_zero
);

   localparam int unsigned CW = clog2(W + 1);
   localparam logic [CW-1:0] LastStep = CW'(W - 1);
   localparam logic [CW-1:0] CntMax   = CW'(W);

   arith_state_e  r_state;
   logic [CW-1:0] r_cnt;
   logic [W:0]    r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_dvs;
   logic          r_busy;
   logic          r_done;
   logic [W-1:0]  r_quotient;
   logic [W-1:0]  r_remainder;
   logic          r_div_by_zero;

   logic [W:0]    w_rem_next;
   logic [W-1:0]  w_quo_next;
   logic [W-1:0]  w_dvd_mag;
   logic [W-1:0]  w_dvs_mag;
   logic [W-1:0]  w_quo_res;
   logic [W-1:0]  w_rem_res;
   logic [W-1:0]  w_zero_rem;

   restoring_div_step #(
      .W (W)
   ) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_dvs),
      .o_rem     (w_rem_next),
      .o_quo     (w_quo_next)
   );

`ifdef SERIAL_DIV_SIGNED_EN
   logic         r_neg_q;
   logic         r_neg_r;
   logic [W-1:0] r_dvd;

   assign w_dvd_mag  = i_dividend[W-1] ? -i_dividend : i_dividend;
   assign w_dvs_mag  = i_divisor[W-1] ? -i_divisor : i_divisor;
   assign w_quo_res  = r_neg_q ? -w_quo_next : w_quo_next;
   assign w_rem_res  = r_neg_r ? -w_rem_next[W-1:0] : w_rem_next[W-1:0];
   assign w_zero_rem = r_dvd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dvd   <= '0;
      end else if (i_start && !r_busy && (r_state == StIdle || r_state == StDone)) begin
         r_neg_q <= i_dividend[W-1] ^ i_divisor[W-1];
         r_neg_r <= i_dividend[W-1];
         r_dvd   <= i_dividend;
      end
   end
`else
   assign w_dvd_mag  = i_dividend;
   assign w_dvs_mag  = i_divisor;
   assign w_quo_res  = w_quo_next;
   assign w_rem_res  = w_rem_next[W-1:0];
   // The shift register still holds the untouched dividend on the zero path.
   assign w_zero_rem = r_quo;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_dvs         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle, StDone: begin
               if (i_start) begin
                  r_cnt         <= '0;
                  r_rem         <= '0;
                  r_quo         <= w_dvd_mag;
                  r_dvs         <= w_dvs_mag;
                  r_busy        <= 1'b1;
                  r_div_by_zero <= 1'b0;
                  r_state       <= (i_divisor == '0) ? StZero : StRun;
               end else begin
                  r_state <= StIdle;
               end
            end
            StRun: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= (r_cnt == CntMax) ? r_cnt : r_cnt + CW'(1);
               if (r_cnt == LastStep) begin
                  r_state     <= StDone;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_quotient  <= w_quo_res;
                  r_remainder <= w_rem_res;
               end
            end
            StZero: begin
               r_state       <= StDone;
               r_busy        <= 1'b0;
               r_done        <= 1'b1;
               r_quotient    <= '1;
               r_remainder   <= w_zero_rem;
               r_div_by_zero <= 1'b1;
            end
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_quotient    = r_quotient;
   assign o_remainder   = r_remainder;
   assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed cases plus random operands against a
// plain-arithmetic reference model.
module tb_serial_divider;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         i_start;
   logic [W-1:0] i_dividend;
   logic [W-1:0] i_divisor;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_quotient;
   logic [W-1:0] o_remainder;
   logic         o_div_by_zero;

   int n_cmp;
   int n_err;
   logic [W-1:0] prev_q;
   logic [W-1:0] prev_r;

   serial_divider #(
      .W (W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_start       (i_start),
      .i_dividend    (i_dividend),
      .i_divisor     (i_divisor),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_quotient    (o_quotient),
      .o_remainder   (o_remainder),
      .o_div_by_zero (o_div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: quotient/remainder straight from the language's division operators.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      int sa;
      int sb;
      dz = (b == '0);
      if (dz) begin
         q = '1;
         r = a;
      end else begin
`ifdef SERIAL_DIV_SIGNED_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
`else
         sa = int'({1'b0, a});
         sb = int'({1'b0, b});
`endif
         q = W'(sa / sb);
         r = W'(sa % sb);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until done, bounded; returns the edge count.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!o_done && lat < 4 * W) begin
         step();
         lat++;
      end
   endtask

   // Issue one operation from idle and check latency, results and the single-cycle done.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
      int           lat;
      model(a, b, eq, er, edz);
      i_dividend = a;
      i_divisor  = b;
      i_start    = 1'b1;
      step();
      i_start = 1'b0;
      check_eq({tag, " busy"}, 32'(o_busy), 32'd1);
      check_eq({tag, " flag clr"}, 32'(o_div_by_zero), 32'd0);
      check_eq({tag, " q hold"}, 32'(o_quotient), 32'(prev_q));
      check_eq({tag, " r hold"}, 32'(o_remainder), 32'(prev_r));
      wait_done(lat);
      check_eq({tag, " latency"}, 32'(lat), (b == '0) ? 32'd1 : 32'(W));
      check_eq({tag, " q"}, 32'(o_quotient), 32'(eq));
      check_eq({tag, " r"}, 32'(o_remainder), 32'(er));
      check_eq({tag, " dz"}, 32'(o_div_by_zero), 32'(edz));
      step();
      check_eq({tag, " done pulse"}, 32'(o_done), 32'd0);
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      bit           saw_done;

      n_cmp      = 0;
      n_err      = 0;
      prev_q     = '0;
      prev_r     = '0;
      reset      = 1'b1;
      i_start    = 1'b0;
      i_dividend = '0;
      i_divisor  = '0;
      step();
      step();
      check_eq("reset busy", 32'(o_busy), 32'd0);
      check_eq("reset done", 32'(o_done), 32'd0);
      check_eq("reset q", 32'(o_quotient), 32'd0);
      check_eq("reset r", 32'(o_remainder), 32'd0);
      check_eq("reset dz", 32'(o_div_by_zero), 32'd0);
      reset = 1'b0;
      step();

      do_op(4'd13, 4'd3, "13/3");
      do_op(4'd5, 4'd0, "5/0");
      do_op(4'd6, 4'd2, "6/2");
      do_op(4'd3, 4'd7, "3/7");
      do_op(4'd15, 4'd1, "15/1");

      // Start during RUN is ignored; then a back-to-back start from the DONE cycle.
      i_dividend = 4'd13;
      i_divisor  = 4'd3;
      i_start    = 1'b1;
      step();
      i_start = 1'b0;
      step();
      i_dividend = 4'd9;
      i_divisor  = 4'd2;
      i_start    = 1'b1;
      step();
      i_start = 1'b0;
      wait_done(lat);
      model(4'd13, 4'd3, eq, er, edz);
      check_eq("ignore done", 32'(o_done), 32'd1);
      check_eq("ignore q", 32'(o_quotient), 32'(eq));
      check_eq("ignore r", 32'(o_remainder), 32'(er));
      i_dividend = 4'd14;
      i_divisor  = 4'd4;
      i_start    = 1'b1;
      step();
      i_start = 1'b0;
      lat = 1;
      while (!o_done && lat < 4 * W) begin
         step();
         lat++;
      end
      model(4'd14, 4'd4, eq, er, edz);
      check_eq("b2b gap", 32'(lat), 32'(W + 1));
      check_eq("b2b q", 32'(o_quotient), 32'(eq));
      check_eq("b2b r", 32'(o_remainder), 32'(er));
      step();

      // Reset in the middle of RUN: outputs clear at once and no done follows.
      i_dividend = 4'd13;
      i_divisor  = 4'd3;
      i_start    = 1'b1;
      step();
      i_start = 1'b0;
      step();
      step();
      #2 reset = 1'b1;
      #1;
      check_eq("abort busy", 32'(o_busy), 32'd0);
      check_eq("abort q", 32'(o_quotient), 32'd0);
      check_eq("abort r", 32'(o_remainder), 32'd0);
      check_eq("abort dz", 32'(o_div_by_zero), 32'd0);
      step();
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
         step();
         if (o_done) saw_done = 1'b1;
      end
      check_eq("abort no done", 32'(saw_done), 32'd0);
      prev_q = '0;
      prev_r = '0;
      do_op(4'd14, 4'd4, "14/4");

`ifdef SERIAL_DIV_SIGNED_EN
      do_op(4'h9, 4'd2, "-7/2");
      do_op(4'h8, 4'hF, "-8/-1");
      do_op(4'h9, 4'd0, "-7/0");
`endif

      for (int i = 0; i < 60; i++) begin
         a = W'($urandom_range(0, (1 << W) - 1));
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
         do_op(a, b, $sformatf("rnd%0d %0h/%0h", i, a, b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
